// File: rtl/frame_tail_tracker.sv
// CAN frame tail tracker: CRC delimiter, ACK slot/delimiter, EOF window and intermission after the last CRC bit.
// Outputs are registered, updating 1 clock after an SP edge; no backpressure, state advances only on SP strobes.
module frame_tail_tracker #(
  parameter int EOF_BITS = 7,
  parameter int INT_BITS = 3,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX,
  input  logic       CRC_End,
  input  logic       Abort,
  output logic       EOF_Flag,
  output logic       CRC_Delim_Error,
  output logic       ACK_Error,
  output logic       ACK_Delim_Error,
  output logic       Overload_Req,
  output logic       Frame_Start,
  output logic       Tail_Idle,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CRC_DEL  = 3'd1,
    S_ACK_SLOT = 3'd2,
    S_ACK_DEL  = 3'd3,
    S_EOF      = 3'd4,
    S_INTER    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_BITS - 1);
  localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             eof_flag_nxt;
  logic             crc_delim_err_nxt, ack_err_nxt, ack_delim_err_nxt;
  logic             overload_nxt, frame_start_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      EOF_Flag        <= 1'b1;
      CRC_Delim_Error <= 1'b1;
      ACK_Error       <= 1'b1;
      ACK_Delim_Error <= 1'b1;
      Overload_Req    <= 1'b0;
      Frame_Start     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      EOF_Flag        <= eof_flag_nxt;
      CRC_Delim_Error <= crc_delim_err_nxt;
      ACK_Error       <= ack_err_nxt;
      ACK_Delim_Error <= ack_delim_err_nxt;
      Overload_Req    <= overload_nxt;
      Frame_Start     <= frame_start_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    eof_flag_nxt      = EOF_Flag;
    crc_delim_err_nxt = CRC_Delim_Error;
    ack_err_nxt       = ACK_Error;
    ack_delim_err_nxt = ACK_Delim_Error;
    overload_nxt      = 1'b0;
    frame_start_nxt   = 1'b0;

    if (SP) begin
      // Abort keeps the sticky error flags so the checker can still read them.
      if (Abort) begin
        state_nxt    = S_IDLE;
        eof_flag_nxt = 1'b1;
        cnt_nxt      = '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (CRC_End) begin
              state_nxt         = S_CRC_DEL;
              crc_delim_err_nxt = 1'b1;
              ack_err_nxt       = 1'b1;
              ack_delim_err_nxt = 1'b1;
            end
          end
          S_CRC_DEL: begin
            if (!RX) begin
              crc_delim_err_nxt = 1'b0;
              state_nxt         = S_IDLE;
            end else begin
              state_nxt = S_ACK_SLOT;
            end
          end
          S_ACK_SLOT: begin
            if (RX) ack_err_nxt = 1'b0;
            state_nxt = S_ACK_DEL;
          end
          S_ACK_DEL: begin
            if (!RX) begin
              ack_delim_err_nxt = 1'b0;
              state_nxt         = S_IDLE;
            end else begin
              eof_flag_nxt = 1'b0;
              cnt_nxt      = '0;
              state_nxt    = S_EOF;
            end
          end
          S_EOF: begin
            // EOF bit levels are judged by the downstream checker, not here.
            if (cnt == EOF_LAST) begin
              eof_flag_nxt = 1'b1;
              cnt_nxt      = '0;
              state_nxt    = S_INTER;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
          S_INTER: begin
            if (cnt == INT_LAST) begin
              if (!RX) frame_start_nxt = 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_IDLE;
            end else if (!RX) begin
              overload_nxt = 1'b1;
              cnt_nxt      = '0;
              state_nxt    = S_IDLE;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
          default: begin
            state_nxt    = S_IDLE;
            eof_flag_nxt = 1'b1;
            cnt_nxt      = '0;
          end
        endcase
      end
    end
  end

  assign Tail_Idle = (state == S_IDLE);
  assign State     = state;

endmodule

// File: tb/tb_frame_tail_tracker.sv
// Bench for frame_tail_tracker: directed tail scenarios plus randomized traffic against a bit-position model.
module tb_frame_tail_tracker;

  localparam int EOF_BITS = 7;
  localparam int INT_BITS = 3;
  localparam int P_EOF    = 3;
  localparam int P_INT    = P_EOF + EOF_BITS;
  localparam int P_END    = P_INT + INT_BITS;
  localparam logic [9:0] RESET_VEC = 10'b1111001000;

  logic       clock;
  logic       reset;
  logic       sp, rx, crc_end, abort;
  logic       eof_flag, crc_delim_error, ack_error, ack_delim_error;
  logic       overload_req, frame_start, tail_idle;
  logic [2:0] state;

  int checks;
  int fails;

  // Model: pos = bit index within the tail after CRC_End (-1 when idle).
  int pos;
  bit m_crc, m_ack, m_ackd, m_ovl, m_fs;

  frame_tail_tracker #(.EOF_BITS(EOF_BITS), .INT_BITS(INT_BITS), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .SP(sp), .RX(rx), .CRC_End(crc_end), .Abort(abort),
    .EOF_Flag(eof_flag), .CRC_Delim_Error(crc_delim_error), .ACK_Error(ack_error),
    .ACK_Delim_Error(ack_delim_error), .Overload_Req(overload_req), .Frame_Start(frame_start),
    .Tail_Idle(tail_idle), .State(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    pos = -1;
    m_crc = 1; m_ack = 1; m_ackd = 1; m_ovl = 0; m_fs = 0;
  endfunction

  function automatic void model_step(input bit s, input bit r, input bit c, input bit a);
    m_ovl = 0;
    m_fs  = 0;
    if (!s) return;
    if (a) begin
      pos = -1;
    end else if (pos < 0) begin
      if (c) begin pos = 0; m_crc = 1; m_ack = 1; m_ackd = 1; end
    end else if (pos == 0) begin
      if (!r) begin m_crc = 0; pos = -1; end else pos = 1;
    end else if (pos == 1) begin
      if (r) m_ack = 0;
      pos = 2;
    end else if (pos == 2) begin
      if (!r) begin m_ackd = 0; pos = -1; end else pos = P_EOF;
    end else if (pos < P_INT) begin
      pos = pos + 1;
    end else if (pos < P_END - 1) begin
      if (!r) begin m_ovl = 1; pos = -1; end else pos = pos + 1;
    end else begin
      if (!r) m_fs = 1;
      pos = -1;
    end
  endfunction

  function automatic logic [9:0] model_vec();
    logic [2:0] st;
    logic       eof_n;
    if (pos < 0) st = 3'd0;
    else if (pos < P_EOF) st = 3'(pos + 1);
    else if (pos < P_INT) st = 3'd4;
    else st = 3'd5;
    eof_n = !(pos >= P_EOF && pos < P_INT);
    return {eof_n, m_crc, m_ack, m_ackd, m_ovl, m_fs, (pos < 0), st};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {eof_flag, crc_delim_error, ack_error, ack_delim_error,
            overload_req, frame_start, tail_idle, state};
  endfunction

  task automatic tick(input bit s, input bit r, input bit c, input bit a);
    sp = s; rx = r; crc_end = c; abort = a;
    @(posedge clock);
    model_step(s, r, c, a);
    @(negedge clock);
  endtask

  task automatic sp_bit(input bit r, input bit c, input bit a, input int gap);
    for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom & 1), 1'b0, 1'b0);
    tick(1'b1, r, c, a);
  endtask

  task automatic test_reset();
    reset = 1'b0; sp = 0; rx = 1; crc_end = 0; abort = 0;
    model_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_hold: got %b expected %b", dut_vec(), RESET_VEC);
    end
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_release: got %b expected %b", dut_vec(), RESET_VEC);
    end
  endtask

  task automatic test_clean_tail(input int gap_max);
    bit bits[13] = '{1,0,1,1,1,1,1,1,1,1,1,1,1};
    int eof_lows = 0;
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 13; i++) begin
      sp_bit(bits[i], 1'b0, 1'b0, $urandom_range(0, gap_max));
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL clean_tail bit %0d: got %b expected %b", i, dut_vec(), model_vec());
      end
      if (eof_flag === 1'b0) eof_lows++;
    end
    checks++;
    if (eof_lows != EOF_BITS) begin
      fails++; $display("FAIL clean_eof_window: got %0d SPs expected %0d", eof_lows, EOF_BITS);
    end
    checks++;
    if ({crc_delim_error, ack_error, ack_delim_error, tail_idle, state} !== 7'b1111000) begin
      fails++; $display("FAIL clean_end_state: got %b expected 1111000",
                        {crc_delim_error, ack_error, ack_delim_error, tail_idle, state});
    end
  endtask

  task automatic test_crc_delim();
    sp_bit(1'b1, 1'b1, 1'b0, 1);
    sp_bit(1'b0, 1'b0, 1'b0, 1);
    checks++;
    if ({crc_delim_error, eof_flag, state} !== 5'b01000) begin
      fails++; $display("FAIL crc_delim: got %b expected 01000", {crc_delim_error, eof_flag, state});
    end
    for (int i = 0; i < 4; i++) begin
      sp_bit(1'($urandom & 1), 1'b0, 1'b0, 1);
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL crc_delim_hold %0d: got %b expected %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_missing_ack();
    int eof_lows = 0;
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 13; i++) begin
      sp_bit(1'b1, 1'b0, 1'b0, 1);
      if (eof_flag === 1'b0) eof_lows++;
    end
    checks++;
    if (ack_error !== 1'b0 || eof_lows != EOF_BITS) begin
      fails++; $display("FAIL missing_ack: ack_error=%b window=%0d expected 0 and %0d",
                        ack_error, eof_lows, EOF_BITS);
    end
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    checks++;
    if ({ack_error, state} !== 4'b1001) begin
      fails++; $display("FAIL ack_clear: got %b expected 1001", {ack_error, state});
    end
    sp_bit(1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_intermission(input int k);
    bit exp_ovl;
    exp_ovl = (k < INT_BITS);
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    sp_bit(1'b1, 1'b0, 1'b0, 0);
    sp_bit(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1 + EOF_BITS + (k - 1); i++) sp_bit(1'b1, 1'b0, 1'b0, 0);
    sp_bit(1'b0, 1'b0, 1'b0, 0);
    checks++;
    if ({overload_req, frame_start, state} !== {exp_ovl, !exp_ovl, 3'd0}) begin
      fails++; $display("FAIL inter_pulse bit %0d: got %b expected %b",
                        k, {overload_req, frame_start, state}, {exp_ovl, !exp_ovl, 3'd0});
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({overload_req, frame_start} !== 2'b00) begin
      fails++; $display("FAIL inter_single bit %0d: got %b expected 00", k, {overload_req, frame_start});
    end
  endtask

  task automatic test_abort();
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    sp_bit(1'b1, 1'b0, 1'b0, 0);
    sp_bit(1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) sp_bit(1'b1, 1'b0, 1'b0, 1);
    checks++;
    if ({eof_flag, state} !== 4'b0100) begin
      fails++; $display("FAIL abort_pre: got %b expected 0100", {eof_flag, state});
    end
    sp_bit(1'b1, 1'b0, 1'b1, 0);
    checks++;
    if ({eof_flag, state, ack_error} !== 5'b10001) begin
      fails++; $display("FAIL abort_eof: got %b expected 10001", {eof_flag, state, ack_error});
    end
    sp_bit(1'b1, 1'b1, 1'b1, 0);
    checks++;
    if ({tail_idle, state} !== 4'b1000) begin
      fails++; $display("FAIL abort_vs_crc_end: got %b expected 1000", {tail_idle, state});
    end
  endtask

  task automatic test_async_reset();
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    sp_bit(1'b1, 1'b1, 1'b0, 0);
    sp_bit(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) sp_bit(1'b1, 1'b0, 1'b0, 0);
    checks++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL rst_pre: got %b expected %b", dut_vec(), model_vec());
    end
    sp = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      fails++; $display("FAIL async_reset: got %b expected %b", dut_vec(), RESET_VEC);
    end
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock);
    test_clean_tail(10);
  endtask

  task automatic test_random();
    bit s, r, c, a;
    for (int i = 0; i < 2000; i++) begin
      s = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 49) == 0);
      tick(s, r, c, a);
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random step %0d: got %b expected %b", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_clean_tail(2);
    test_crc_delim();
    test_missing_ack();
    test_intermission(2);
    test_intermission(3);
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
